cpc_bank_ctrl: RTL and testbench
================================

CPC_BANK_CTRL -- requirements
Module: cpc_bank_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 8: number of populated 64K expansion banks, legal range 1..8.
REQ-002 clock  input  1  Z80 system clock; all state changes on its rising edge.
REQ-003 resetb  input  1  asynchronous, active-low reset.
REQ-004 adr  input  16  Z80 address bus.
REQ-005 data  input  8  Z80 data bus, sampled during I/O writes.
REQ-006 iorq_b  input  1  Z80 IORQ, active low.
REQ-007 wr_b  input  1  Z80 WR, active low.
REQ-008 mreq_b  input  1  Z80 MREQ, active low.
REQ-009 exp_cs_b  output  1  expansion RAM chip select, active low.
REQ-010 exp_bank  output  3  64K bank select to expansion RAM (A18:A16).
REQ-011 exp_page  output  2  16K page within bank (A15:A14 to expansion RAM).
REQ-012 ramdis  output  1  high to disable internal RAM for the current access.
REQ-013 cfg  output  6  current latched configuration {bank[2:0], mode[2:0]}, for debug.

Function
REQ-014 A config write SHALL be detected when, at a rising clock edge, iorq_b=0, wr_b=0, adr[15]=0 and data[7:6]=2'b11.
REQ-015 Controller SHALL be a 3-state FSM: IDLE, LATCH, WAIT_END.
REQ-016 IDLE -> LATCH on detected config write; otherwise remain IDLE.
REQ-017 In LATCH, cfg SHALL load data[5:0] as sampled at that edge; the FSM then moves unconditionally to WAIT_END (config update latency: 2 clock edges from first detection).
REQ-018 If data[7:6] is no longer 2'b11 or iorq_b is high at the LATCH edge, the load SHALL be cancelled and the FSM SHALL return to IDLE.
REQ-019 WAIT_END -> IDLE only when iorq_b=1 or wr_b=1 is sampled; at most one load per I/O bus cycle.
REQ-020 Writes with adr[15]=1 or data[7:6]!=2'b11 SHALL never alter cfg.
REQ-021 Mapping is combinational from cfg, adr[15:14] and mreq_b; with mode=cfg[2:0], slot=adr[15:14]:
  - mode 0: no expansion.
  - mode 1: slot 3 -> page 3.
  - mode 2: slot n -> page n for all four slots.
  - mode 3: slot 3 -> page 3.
  - modes 4..7: slot 1 -> page (mode-4).
REQ-022 When a slot is mapped, mreq_b=0, and cfg[5:3] < NUM_BANKS: exp_cs_b=0, ramdis=1, exp_bank=cfg[5:3], exp_page per REQ-021.
REQ-023 Otherwise exp_cs_b=1 and ramdis=0; exp_bank and exp_page SHALL still drive cfg[5:3] and adr[15:14].
REQ-024 Bank number >= NUM_BANKS SHALL be latched into cfg but SHALL suppress all expansion selects.

Reset
REQ-025 While resetb=0: FSM=IDLE, cfg=6'b000000, so exp_cs_b=1, ramdis=0, exp_bank=0.
REQ-026 Reset asserted in LATCH or WAIT_END SHALL abort the load; after release the FSM SHALL re-arm only after a new IDLE detection.
REQ-027 Release of resetb while a qualifying I/O write is active SHALL be detected normally on the next rising edge.

Structure
REQ-028 FSM state encodings and the mode-to-page mapping constants SHALL live in a shared package, cpc_bank_pkg.
REQ-029 The combinational mapper SHALL be a sub-module, cpc_bank_map (inputs cfg, adr[15:14], mreq_b; outputs exp_cs_b, exp_bank, exp_page, ramdis); the FSM and cfg register stay in cpc_bank_ctrl.

Verification
REQ-030 Reset, then memory read at adr=16'hC000 -> exp_cs_b=1, ramdis=0, cfg=6'h00.
REQ-031 I/O write adr=16'h7F00 data=8'hC1, 3 clocks; then read adr=16'hC123 -> cfg=6'h01, exp_cs_b=0, exp_page=3, exp_bank=0; read at adr=16'h4000 -> exp_cs_b=1.
REQ-032 I/O write data=8'hEE (bank 5, mode 6); read adr=16'h4000 -> exp_bank=5, exp_page=2, exp_cs_b=0, ramdis=1; with NUM_BANKS=4 and data=8'hF6 -> exp_cs_b=1, ramdis=0.
REQ-033 I/O write adr=16'hFF00 data=8'hC2, and adr=16'h7F00 data=8'h82 -> cfg unchanged.
REQ-034 Write data=8'hC2 held 6 clocks; mid-cycle data changes to 8'hC7 -> exactly one load, cfg=6'h02.
REQ-035 resetb pulsed low during WAIT_END after loading 8'hC4 -> cfg=0, exp_cs_b=1 immediately (asynchronous).

Source files
------------

// File: rtl/cpc_bank_pkg.sv
// cpc_bank_pkg
// Shared definitions for the CPC expansion RAM bank controller.
// Holds the controller FSM state encoding, the config-byte tag value and the
// mode/slot constants, plus slot_map(), which gives the expansion page for a
// slot under a mode. slot_map() ignores MREQ and the populated-bank limit.

package cpc_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LATCH    = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  // data[7:6] value that marks an I/O write as a bank configuration byte
  localparam logic [1:0] CFG_TAG = 2'b11;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_TOP     = 3'd1;
  localparam logic [2:0] MODE_ALL     = 3'd2;
  localparam logic [2:0] MODE_TOP_ALT = 3'd3;

  // Slot 3 (C000-FFFF) is the slot remapped by modes 1 and 3.
  localparam logic [1:0] SLOT_TOP = 2'd3;
  // Slot 1 (4000-7FFF) is the window used by modes 4..7.
  localparam logic [1:0] SLOT_WIN = 2'd1;

  typedef struct packed {
    logic       hit;
    logic [1:0] page;
  } map_t;

  function automatic map_t slot_map(input logic [2:0] mode, input logic [1:0] slot);
    map_t m;
    m.hit  = 1'b0;
    m.page = slot;
    case (mode)
      MODE_OFF: m.hit = 1'b0;
      MODE_TOP, MODE_TOP_ALT: m.hit = (slot == SLOT_TOP);
      MODE_ALL: m.hit = 1'b1;
      default: begin
        // Modes 4..7 place page (mode-4) in the slot 1 window.
        // mode-4 equals mode[1:0] for these modes.
        if (slot == SLOT_WIN) begin
          m.hit  = 1'b1;
          m.page = mode[1:0];
        end
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cpc_bank_map.sv
// cpc_bank_map
// Combinational address mapper for the expansion RAM.
// Ports:
//   cfg      in  6  latched configuration {bank[2:0], mode[2:0]}
//   adr_hi   in  2  Z80 adr[15:14] (the 16K slot being accessed)
//   mreq_b   in  1  Z80 MREQ, active low
//   exp_cs_b out 1  expansion RAM chip select, active low
//   exp_bank out 3  64K bank select (A18:A16), always cfg[5:3]
//   exp_page out 2  16K page (A15:A14); adr_hi when the slot is not selected
//   ramdis   out 1  high to disable internal RAM for the current access

module cpc_bank_map
  import cpc_bank_pkg::*;
#(
  parameter int NUM_BANKS = 8
) (
  input  logic [5:0] cfg,
  input  logic [1:0] adr_hi,
  input  logic       mreq_b,
  output logic       exp_cs_b,
  output logic [2:0] exp_bank,
  output logic [1:0] exp_page,
  output logic       ramdis
);

  localparam logic [3:0] BANK_LIMIT = 4'(NUM_BANKS);

  map_t slot_m;
  logic bank_ok;
  logic sel;

  // A bank number at or above the populated count is still latched in cfg.
  // It blocks every select, so the access falls through to internal RAM.
  always_comb begin
    slot_m   = slot_map(cfg[2:0], adr_hi);
    bank_ok  = ({1'b0, cfg[5:3]} < BANK_LIMIT);
    sel      = slot_m.hit && !mreq_b && bank_ok;
    exp_cs_b = !sel;
    ramdis   = sel;
    exp_bank = cfg[5:3];
    exp_page = sel ? slot_m.page : adr_hi;
  end

endmodule

// File: rtl/cpc_bank_ctrl.sv
// cpc_bank_ctrl
// Controller for the CPC expansion RAM banks. The controller watches Z80 I/O
// writes for a configuration byte. A configuration byte has adr[15]=0 and
// data[7:6]=11. The controller latches data[5:0] into cfg and drives the
// combinational mapper from it.
// Ports:
//   clock    in  1   Z80 system clock, rising edge
//   resetb   in  1   asynchronous active-low reset
//   adr      in  16  Z80 address bus
//   data     in  8   Z80 data bus
//   iorq_b   in  1   Z80 IORQ, active low
//   wr_b     in  1   Z80 WR, active low
//   mreq_b   in  1   Z80 MREQ, active low
//   exp_cs_b out 1   expansion RAM chip select, active low
//   exp_bank out 3   64K bank select (A18:A16)
//   exp_page out 2   16K page (A15:A14)
//   ramdis   out 1   internal RAM disable
//   cfg      out 6   latched configuration {bank, mode}

module cpc_bank_ctrl
  import cpc_bank_pkg::*;
#(
  parameter int NUM_BANKS = 8
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [15:0] adr,
  input  logic [7:0]  data,
  input  logic        iorq_b,
  input  logic        wr_b,
  input  logic        mreq_b,
  output logic        exp_cs_b,
  output logic [2:0]  exp_bank,
  output logic [1:0]  exp_page,
  output logic        ramdis,
  output logic [5:0]  cfg
);

  state_t state;
  logic   cfg_write;

  // Only adr[15] and adr[15:14] are decoded; the low address bits are unused.
  logic unused_adr;
  assign unused_adr = &{1'b0, adr[13:0]};

  assign cfg_write = !iorq_b && !wr_b && !adr[15] && (data[7:6] == CFG_TAG);

  // The write is qualified again at the LATCH edge. A bus that changed since
  // detection then cancels the load instead of latching a stray value.
  // WAIT_END holds until the I/O cycle ends, so one bus cycle loads once.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      cfg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_write) state <= ST_LATCH;
        end
        ST_LATCH: begin
          if (cfg_write) begin
            cfg   <= data[5:0];
            state <= ST_WAIT_END;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_END: begin
          if (iorq_b || wr_b) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cpc_bank_map #(
    .NUM_BANKS (NUM_BANKS)
  ) u_map (
    .cfg      (cfg),
    .adr_hi   (adr[15:14]),
    .mreq_b   (mreq_b),
    .exp_cs_b (exp_cs_b),
    .exp_bank (exp_bank),
    .exp_page (exp_page),
    .ramdis   (ramdis)
  );

endmodule

// File: tb/tb_cpc_bank_ctrl.sv
// tb_cpc_bank_ctrl
// Testbench for cpc_bank_ctrl. It drives one Z80 bus into two instances.
// The first instance has 8 populated banks and the second has 4.
// Expected outputs come from a bank-mapping model in this file and from cfg
// values tracked by the stimulus sequence. Each probe pushes expected entries
// to a scoreboard queue, then pops them and compares once outputs settle.

module tb_cpc_bank_ctrl;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] adr = 16'h0000;
  logic [7:0]  data = 8'h00;
  logic        iorq_b = 1'b1;
  logic        wr_b = 1'b1;
  logic        mreq_b = 1'b1;

  logic       a_cs_b, a_ramdis, b_cs_b, b_ramdis;
  logic [2:0] a_bank, b_bank;
  logic [1:0] a_page, b_page;
  logic [5:0] a_cfg, b_cfg;

  typedef struct {
    string      tag;
    int         which;
    logic [5:0] cfg;
    logic       cs_b;
    logic       ramdis;
    logic [2:0] bank;
    logic [1:0] page;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] exp_cfg = 6'h00;

  always #5 clock = ~clock;

  cpc_bank_ctrl #(.NUM_BANKS(8)) dut8 (
    .clock(clock), .resetb(resetb), .adr(adr), .data(data),
    .iorq_b(iorq_b), .wr_b(wr_b), .mreq_b(mreq_b),
    .exp_cs_b(a_cs_b), .exp_bank(a_bank), .exp_page(a_page),
    .ramdis(a_ramdis), .cfg(a_cfg)
  );

  cpc_bank_ctrl #(.NUM_BANKS(4)) dut4 (
    .clock(clock), .resetb(resetb), .adr(adr), .data(data),
    .iorq_b(iorq_b), .wr_b(wr_b), .mreq_b(mreq_b),
    .exp_cs_b(b_cs_b), .exp_bank(b_bank), .exp_page(b_page),
    .ramdis(b_ramdis), .cfg(b_cfg)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Mapping model written directly from the mode table
  function automatic exp_t modelMap(input logic [5:0] c, input logic [1:0] slot,
                                    input logic mreq, input int nb);
    exp_t e;
    logic hit;
    logic [1:0] pg;
    hit = 1'b0;
    pg  = slot;
    case (c[2:0])
      3'd0: hit = 1'b0;
      3'd1: if (slot == 2'd3) begin hit = 1'b1; pg = 2'd3; end
      3'd2: begin hit = 1'b1; pg = slot; end
      3'd3: if (slot == 2'd3) begin hit = 1'b1; pg = 2'd3; end
      3'd4: if (slot == 2'd1) begin hit = 1'b1; pg = 2'd0; end
      3'd5: if (slot == 2'd1) begin hit = 1'b1; pg = 2'd1; end
      3'd6: if (slot == 2'd1) begin hit = 1'b1; pg = 2'd2; end
      default: if (slot == 2'd1) begin hit = 1'b1; pg = 2'd3; end
    endcase
    e.tag   = "";
    e.which = 0;
    e.cfg   = c;
    e.bank  = c[5:3];
    if (hit && !mreq && (int'(c[5:3]) < nb)) begin
      e.cs_b   = 1'b0;
      e.ramdis = 1'b1;
      e.page   = pg;
    end else begin
      e.cs_b   = 1'b1;
      e.ramdis = 1'b0;
      e.page   = slot;
    end
    return e;
  endfunction

  // Push expectations for both instances at the present bus state, then
  // pop and compare once the combinational outputs have settled.
  task automatic probe(input string tag);
    exp_t e;
    for (int w = 0; w < 2; w++) begin
      e = modelMap(exp_cfg, adr[15:14], mreq_b, (w == 0) ? 8 : 4);
      e.tag = tag;
      e.which = w;
      sb.push_back(e);
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which == 0) begin
        checkOutput({e.tag, "/n8.cfg"},  {2'b00, a_cfg},    {2'b00, e.cfg});
        checkOutput({e.tag, "/n8.cs_b"}, {7'd0, a_cs_b},    {7'd0, e.cs_b});
        checkOutput({e.tag, "/n8.rdis"}, {7'd0, a_ramdis},  {7'd0, e.ramdis});
        checkOutput({e.tag, "/n8.bank"}, {5'd0, a_bank},    {5'd0, e.bank});
        checkOutput({e.tag, "/n8.page"}, {6'd0, a_page},    {6'd0, e.page});
      end else begin
        checkOutput({e.tag, "/n4.cfg"},  {2'b00, b_cfg},    {2'b00, e.cfg});
        checkOutput({e.tag, "/n4.cs_b"}, {7'd0, b_cs_b},    {7'd0, e.cs_b});
        checkOutput({e.tag, "/n4.rdis"}, {7'd0, b_ramdis},  {7'd0, e.ramdis});
        checkOutput({e.tag, "/n4.bank"}, {5'd0, b_bank},    {5'd0, e.bank});
        checkOutput({e.tag, "/n4.page"}, {6'd0, b_page},    {6'd0, e.page});
      end
    end
  endtask

  task automatic memRead(input string tag, input logic [15:0] a);
    @(negedge clock);
    adr    = a;
    mreq_b = 1'b0;
    probe(tag);
    mreq_b = 1'b1;
  endtask

  // One I/O write held for n rising edges, followed by the end of the cycle
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input int n);
    @(negedge clock);
    adr    = a;
    data   = d;
    iorq_b = 1'b0;
    wr_b   = 1'b0;
    repeat (n) @(posedge clock);
    @(negedge clock);
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] d;

    // Reset state with a memory read active
    adr    = 16'hC000;
    mreq_b = 1'b0;
    #2;
    probe("reset_held");
    mreq_b = 1'b1;
    @(negedge clock);
    resetb = 1'b1;

    memRead("rd_c000", 16'hC000);

    // Mode 1, bank 0
    applyStimulus(16'h7F00, 8'hC1, 3);
    exp_cfg = 6'h01;
    memRead("m1_c123", 16'hC123);
    memRead("m1_4000", 16'h4000);

    // Bank 5, mode 6, then bank 6 (beyond the 4-bank instance)
    applyStimulus(16'h7F00, 8'hEE, 3);
    exp_cfg = 6'h2E;
    memRead("b5m6_4000", 16'h4000);
    applyStimulus(16'h7F00, 8'hF6, 3);
    exp_cfg = 6'h36;
    memRead("b6m6_4000", 16'h4000);

    // Non-config writes leave cfg alone
    applyStimulus(16'hFF00, 8'hC2, 3);
    memRead("adr15_ign", 16'h4000);
    applyStimulus(16'h7F00, 8'h82, 3);
    memRead("tag_ign", 16'h4000);

    // Long write with a mid-cycle data change loads exactly once
    @(negedge clock);
    adr = 16'h7F00; data = 8'hC2; iorq_b = 1'b0; wr_b = 1'b0;
    @(posedge clock);
    @(negedge clock);
    probe("lat_edge1");
    @(posedge clock);
    exp_cfg = 6'h02;
    @(posedge clock);
    @(negedge clock);
    data = 8'hC7;
    probe("hold_mid");
    repeat (3) @(posedge clock);
    @(negedge clock);
    probe("hold_end");
    iorq_b = 1'b1; wr_b = 1'b1;
    @(posedge clock);

    // Data loses its tag at the LATCH edge: load cancelled
    @(negedge clock);
    adr = 16'h7F00; data = 8'hC5; iorq_b = 1'b0; wr_b = 1'b0;
    @(posedge clock);
    @(negedge clock);
    data = 8'h05;
    @(posedge clock);
    @(negedge clock);
    iorq_b = 1'b1; wr_b = 1'b1;
    probe("cancel_data");
    @(posedge clock);

    // IORQ released at the LATCH edge: load cancelled
    @(negedge clock);
    data = 8'hC5; iorq_b = 1'b0; wr_b = 1'b0;
    @(posedge clock);
    @(negedge clock);
    iorq_b = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wr_b = 1'b1;
    probe("cancel_iorq");

    // Every mode across every slot, banks 7..0
    for (int m = 0; m < 8; m++) begin
      d = {2'b11, 3'(7 - m), 3'(m)};
      applyStimulus(16'h7F00, d, 2);
      exp_cfg = d[5:0];
      for (int s = 0; s < 4; s++) begin
        memRead($sformatf("sweep_m%0d_s%0d", m, s), {2'(s), 14'h0123});
      end
    end

    // Asynchronous reset in WAIT_END, then re-detection of the still-active write
    @(negedge clock);
    adr = 16'h7F00; data = 8'hC4; iorq_b = 1'b0; wr_b = 1'b0; mreq_b = 1'b0;
    @(posedge clock);
    @(posedge clock);
    exp_cfg = 6'h04;
    @(negedge clock);
    probe("c4_loaded");
    #2;
    resetb = 1'b0;
    exp_cfg = 6'h00;
    probe("async_rst");
    @(negedge clock);
    resetb = 1'b1;
    @(posedge clock);
    @(negedge clock);
    probe("rearm_edge1");
    @(posedge clock);
    exp_cfg = 6'h04;
    @(negedge clock);
    probe("rearm_edge2");
    iorq_b = 1'b1; wr_b = 1'b1; mreq_b = 1'b1;
    @(posedge clock);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
